// File: rtl/irq_controller_pkg.sv
// Shared definitions for the vectored interrupt controller: register offsets,
// controller states and the IRQ_ID valid-flag position.
package irq_ctrl_pkg;

   localparam logic [3:0] ADDR_IRQ_ID  = 4'h0;
   localparam logic [3:0] ADDR_MASK    = 4'h1;
   localparam logic [3:0] ADDR_PENDING = 4'h2;
   localparam logic [3:0] ADDR_MODE    = 4'h3;
   localparam logic [3:0] ADDR_RAW     = 4'h4;

   localparam int VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set index of vec_i and whether any
// bit is set.
module irq_priority_encoder #(
   parameter int N    = 16,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    vec_i,
   output logic [ID_W-1:0] id_o,
   output logic            valid_o
);

   // Scan from the top down so the lowest set index is the last assignment.
   always_comb begin
      id_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) id_o = ID_W'(i);
      end
   end

   assign valid_o = |vec_i;

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: per-source mask and level/edge mode, fixed
// priority vector read and an in-service/ack handshake towards the CPU.
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int N_SOURCES   = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int ID_WIDTH    = $clog2(N_SOURCES),
   parameter int SYNC_STAGES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  rw,
   input  logic [3:0]            address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic [N_SOURCES-1:0]  irq_src,
   output logic                  irq,
   input  logic                  ack
);

   logic [N_SOURCES-1:0] raw;
   logic [N_SOURCES-1:0] raw_prev_q;
   logic [N_SOURCES-1:0] mask_q, mask_d;
   logic [N_SOURCES-1:0] mode_q, mode_d;
   logic [N_SOURCES-1:0] edge_q, edge_d;
   logic [N_SOURCES-1:0] w1c, ack_clr, edge_set;
   logic [N_SOURCES-1:0] pending, active;
   logic [ID_WIDTH-1:0]  enc_id, isid_q, id_val;
   logic                 enc_valid, id_valid;
   logic                 wr_en, rd_en, id_read;
   logic                 irq_q;
   irq_state_e           state_q;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                 unused_data_in;

   assign unused_data_in = ^data_in;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign raw = irq_src;
      end else begin : g_sync
         logic [N_SOURCES-1:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            end else begin
               sync_q[0] <= irq_src;
               for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            end
         end
         assign raw = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign wr_en   = ce & rw;
   assign rd_en   = ce & ~rw;
   assign id_read = rd_en && (address == ADDR_IRQ_ID);

   always_comb begin
      mask_d = mask_q;
      mode_d = mode_q;
      w1c    = '0;
      if (wr_en) begin
         case (address)
            ADDR_MASK:    mask_d = data_in[N_SOURCES-1:0];
            ADDR_MODE:    mode_d = data_in[N_SOURCES-1:0];
            ADDR_PENDING: w1c    = data_in[N_SOURCES-1:0];
            default:      ;
         endcase
      end
   end

   // Edge set beats any clear in the same cycle; leaving edge mode drops the stored bit.
   always_comb begin
      ack_clr = '0;
      if (state_q == SERVICE && ack) ack_clr[isid_q] = 1'b1;
      edge_set = raw & ~raw_prev_q;
      edge_d   = ((edge_q & ~(w1c | ack_clr)) | edge_set) & mode_d;
   end

   assign pending = (edge_q & mode_q) | (raw & ~mode_q);
   assign active  = pending & mask_q;

   irq_priority_encoder #(
      .N    (N_SOURCES),
      .ID_W (ID_WIDTH)
   ) u_prio (
      .vec_i   (active),
      .id_o    (enc_id),
      .valid_o (enc_valid)
   );

   assign id_valid = (state_q == SERVICE) ? 1'b1 : enc_valid;
   assign id_val   = (state_q == SERVICE) ? isid_q : enc_id;

   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         case (address)
            ADDR_IRQ_ID: begin
               rd_data[ID_WIDTH-1:0] = id_val;
               rd_data[VALID_BIT]    = id_valid;
            end
            ADDR_MASK:    rd_data = DATA_WIDTH'(mask_q);
            ADDR_PENDING: rd_data = DATA_WIDTH'(pending);
            ADDR_MODE:    rd_data = DATA_WIDTH'(mode_q);
            ADDR_RAW:     rd_data = DATA_WIDTH'(raw);
            default:      rd_data = '0;
         endcase
      end
   end

   assign data_out = rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q     <= '0;
         mode_q     <= '0;
         edge_q     <= '0;
         raw_prev_q <= '0;
      end else begin
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         edge_q     <= edge_d;
         raw_prev_q <= raw;
      end
   end

   // Request/service handshake; irq is registered so it lags pending by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         isid_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enc_valid) begin
                  state_q <= REQ;
                  irq_q   <= 1'b1;
               end
            end
            REQ: begin
               if (!enc_valid) begin
                  state_q <= IDLE;
                  irq_q   <= 1'b0;
               end else if (id_read) begin
                  state_q <= SERVICE;
                  isid_q  <= enc_id;
                  irq_q   <= 1'b0;
               end
            end
            SERVICE: begin
               irq_q <= 1'b0;
               if (ack) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign irq = irq_q;

endmodule
